// File: rtl/req_arb_pkg.sv
// Shared constants, state encoding and reset values for the round-robin
// request arbiter and its picker.
package req_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  localparam logic [N_REQ-1:0] GNT_RST = '0;
  localparam logic [IDX_W-1:0] IDX_RST = '0;

endpackage

// File: rtl/req_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set pending bit at or
// after ptr, wrapping modulo N, and returns it as one-hot plus index.
module rr_pick
  import req_arb_pkg::*;
#(
  parameter int N = N_REQ,
  parameter int W = IDX_W
) (
  input  logic [N-1:0] pending_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] onehot_o,
  output logic [W-1:0] index_o,
  output logic         any_o
);

  logic [N-1:0] rotated;
  logic [W-1:0] offset;

  // Rotating right by ptr puts the highest-priority candidate at bit 0.
  assign rotated = N'({pending_i, pending_i} >> ptr_i);

  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = W'(i);
      end
    end
  end

  assign any_o    = |pending_i;
  assign index_o  = ptr_i + offset;
  assign onehot_o = any_o ? (N'(1) << index_o) : '0;

endmodule

// File: rtl/req_rr_arbiter.sv
// Round-robin request arbiter: latches request pulses into a pending
// register and offers them one at a time under a valid/ready handshake.
module req_rr_arbiter
  import req_arb_pkg::*;
#(
  parameter int N = N_REQ,
  parameter int W = IDX_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  input  logic         ready_i,
  input  logic         clr_err_i,
  output logic         valid_o,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] pending_o,
  output logic         drop_err_o
);

  arb_state_e   state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [W-1:0] idx_q, idx_d;
  logic         valid_q, valid_d;
  logic         drop_err_q, drop_err_d;

  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic         accept;
  logic         drop;

  logic [N-1:0] pick_onehot;
  logic [W-1:0] pick_index;
  logic         pick_any;

  rr_pick #(
    .N(N),
    .W(W)
  ) u_pick (
    .pending_i(pending_q),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .index_o  (pick_index),
    .any_o    (pick_any)
  );

  // A new request on the bit being accepted this cycle re-arms it.
  assign accept    = valid_q & ready_i;
  assign set_vec   = req_i & {N{en_i}};
  assign clr_vec   = accept ? gnt_q : '0;
  assign pending_d = (pending_q & ~clr_vec) | set_vec;
  assign drop      = |(set_vec & pending_q & ~clr_vec);

  always_comb begin
    drop_err_d = drop_err_q;
    if (drop) begin
      drop_err_d = 1'b1;
    end else if (clr_err_i) begin
      drop_err_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_onehot;
          idx_d   = pick_index;
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (ready_i) begin
          ptr_d   = idx_q + W'(1);
          gnt_d   = N'(GNT_RST);
          idx_d   = W'(IDX_RST);
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      pending_q  <= '0;
      gnt_q      <= N'(GNT_RST);
      idx_q      <= W'(IDX_RST);
      valid_q    <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign valid_o    = valid_q;
  assign gnt_o      = gnt_q;
  assign idx_o      = idx_q;
  assign pending_o  = pending_q;
  assign drop_err_o = drop_err_q;

endmodule

// File: tb/tb_req_rr_arbiter.sv
// Directed bench for req_rr_arbiter; accepted grants are checked against a
// queue of expected indices filled as requests are driven.
module tb_req_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       ready;
  logic       clrErr;
  logic       valid;
  logic [7:0] gnt;
  logic [2:0] idx;
  logic [7:0] pending;
  logic       dropErr;

  int checks = 0;
  int errors = 0;
  int expQ[$];
  int expIdx;

  req_rr_arbiter #(
    .N(8),
    .W(3)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .req_i     (req),
    .ready_i   (ready),
    .clr_err_i (clrErr),
    .valid_o   (valid),
    .gnt_o     (gnt),
    .idx_o     (idx),
    .pending_o (pending),
    .drop_err_o(dropErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] reqV, input logic enV,
                               input logic readyV, input logic clrV);
    req    = reqV;
    en     = enV;
    ready  = readyV;
    clrErr = clrV;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_timeout", expQ.size(), 0);
  endtask

  // Scoreboard: the handshake seen mid-cycle completes at the next edge.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_unexpected_grant", idx, 32'hFFFF);
      end else begin
        expIdx = expQ.pop_front();
        checkOutput("sb_idx", idx, expIdx);
        checkOutput("sb_gnt", gnt, 32'(1) << expIdx);
      end
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_idx", idx, 0);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_drop", dropErr, 0);

    $display("[TB] single request latency");
    applyStimulus(8'h04, 1'b1, 1'b1, 1'b0);
    expQ.push_back(2);
    tick();
    req = 8'h00;
    checkOutput("lat_c1_pending", pending, 8'h04);
    checkOutput("lat_c1_valid", valid, 0);
    tick();
    checkOutput("lat_c2_valid", valid, 1);
    checkOutput("lat_c2_gnt", gnt, 8'h04);
    checkOutput("lat_c2_idx", idx, 2);
    tick();
    checkOutput("lat_c3_valid", valid, 0);
    checkOutput("lat_c3_pending", pending, 0);

    $display("[TB] all eight from reset pointer");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) expQ.push_back(i);
    tick();
    req = 8'h00;
    drain(40);
    checkOutput("all8_pending", pending, 0);

    $display("[TB] wrap-around fairness");
    req = 8'h10;
    expQ.push_back(4);
    tick();
    req = 8'h00;
    drain(10);
    req = 8'h42;
    expQ.push_back(6);
    expQ.push_back(1);
    tick();
    req = 8'h00;
    drain(20);

    $display("[TB] hold under backpressure");
    applyStimulus(8'h08, 1'b1, 1'b0, 1'b0);
    expQ.push_back(3);
    tick();
    req = 8'h00;
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", valid, 1);
      checkOutput("hold_gnt", gnt, 8'h08);
      checkOutput("hold_idx", idx, 3);
      tick();
    end
    ready = 1'b1;
    checkOutput("hold_last_valid", valid, 1);
    tick();
    checkOutput("hold_after_valid", valid, 0);
    checkOutput("hold_queue", expQ.size(), 0);

    $display("[TB] drop detection and collision");
    applyStimulus(8'h04, 1'b1, 1'b0, 1'b0);
    expQ.push_back(2);
    tick();
    req = 8'h00;
    tick();
    checkOutput("drop_pre", dropErr, 0);
    req = 8'h04;
    tick();
    req = 8'h00;
    checkOutput("drop_set", dropErr, 1);
    tick();
    checkOutput("drop_sticky", dropErr, 1);
    clrErr = 1'b1;
    tick();
    clrErr = 1'b0;
    checkOutput("drop_cleared", dropErr, 0);
    applyStimulus(8'h04, 1'b1, 1'b1, 1'b0);
    expQ.push_back(2);
    tick();
    req = 8'h00;
    checkOutput("collide_pending", pending, 8'h04);
    checkOutput("collide_drop", dropErr, 0);
    checkOutput("collide_valid", valid, 0);
    drain(10);

    $display("[TB] capture disable and mid-offer reset");
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
    expQ.push_back(0);
    tick();
    req = 8'h00;
    tick();
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("en0_pending", pending, 8'h01);
    checkOutput("en0_drop", dropErr, 0);
    checkOutput("en0_valid", valid, 1);
    checkOutput("en0_idx", idx, 0);
    rst = 1'b1;
    tick();
    expQ.delete();
    checkOutput("mid_rst_valid", valid, 0);
    checkOutput("mid_rst_gnt", gnt, 0);
    checkOutput("mid_rst_idx", idx, 0);
    checkOutput("mid_rst_pending", pending, 0);
    checkOutput("mid_rst_drop", dropErr, 0);
    rst = 1'b0;
    applyStimulus(8'h81, 1'b1, 1'b1, 1'b0);
    expQ.push_back(0);
    expQ.push_back(7);
    tick();
    req = 8'h00;
    drain(20);
    checkOutput("final_pending", pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_rr_arbiter.md
# req_rr_arbiter

Round-robin request arbiter that sits directly upstream of the 8-to-3 priority encoder. It latches single-cycle request pulses from up to eight sources into a pending register and offers one request at a time. Each offer is a one-hot grant (which feeds the encoder's data input) plus a registered 3-bit index, held under a valid/ready handshake. A sticky error flag reports requests lost because their source was already pending.

## Interface
- N, 8, number of request sources; N is a power of two and N ≥ 2
- W, 3, index width, equal to log2(N)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  capture enable; when low, new req bits are ignored
- req  in  N  request pulses, one bit per source
- ready  in  1  downstream accepts the current offer
- clr_err  in  1  clears drop_err
- valid  out  1  an offer is present on gnt/idx
- gnt  out  N  one-hot grant; all zero when valid=0
- idx  out  W  binary index of the granted bit; zero when valid=0
- pending  out  N  registered pending vector, for debug/status
- drop_err  out  1  sticky flag: a request was dropped

The clock and reset arrangement is fixed: one clock, clk; reset rst is synchronous and active-high.

## Operation
- Capture is a per-bit update every cycle.
  - set = req & {N{en}}
  - clr = gnt when (valid & ready), else 0
  - pending_next = (pending & ~clr) | set
  - If set and clr hit the same bit in the same cycle, set wins and the bit stays pending.
- Drop detection: drop_err is set when any bit has set=1 while pending=1 and clr=0 for that bit.
  - clr_err clears drop_err.
  - If a new drop and clr_err occur in the same cycle, the set wins.
- The FSM has two states, IDLE and OFFER.
- IDLE:
  - If pending ≠ 0, pick the first set bit at or after ptr, wrapping modulo N.
  - Load gnt (one-hot) and idx, assert valid, go to OFFER.
  - If pending = 0, stay in IDLE with valid=0.
- OFFER:
  - gnt, idx and valid are held stable until ready=1.
  - On valid & ready: clear the pending bit, set ptr = (idx+1) mod N, deassert valid, return to IDLE.
  - valid never drops without a handshake (except on reset).
- en affects capture only. Bits already pending are still offered while en=0.
- ptr is W bits wide and wraps naturally from N-1 to 0.
- On a reset in mid-operation, everything returns to reset values on the next edge. Any in-flight offer and all pending bits are lost, and no handshake completes in that cycle.

## Timing
- Reset values: valid=0, gnt=0, idx=0, pending=0, drop_err=0, ptr=0, state=IDLE.
- Latency, req to offer: a req pulse in cycle 0 gives pending set in cycle 1 and valid=1 in cycle 2 (when the FSM is in IDLE).
- Handshake: accepted at the rising edge where valid & ready = 1. valid is low in the following cycle, giving a one-cycle bubble. Peak throughput is one grant per 2 cycles.
- ready may be asserted before valid. It has no effect while valid=0.
- The pending output reflects the register, so a cleared bit reads 0 in the cycle after acceptance.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Shared package req_arb_pkg holds:
  - constants N_REQ=8 and IDX_W=3
  - the state enum {IDLE, OFFER}
  - the reset-value constants for gnt and idx
- One sub-module, rr_pick, which is combinational:
  - inputs: pending[N], ptr[W]
  - outputs: onehot[N], index[W], any
  - implemented as a double-width priority scan or a rotate/priority/unrotate
- The top level holds the pending register, the drop logic, the FSM and ptr.

## Test plan
- Reset, then req=8'b0000_0100 for one cycle with en=1 and ready=1 → cycle 2 gives valid=1, gnt=8'b0000_0100, idx=3'd2; cycle 3 gives valid=0 and pending=0.
- req=8'hFF in one cycle, ready held high → grants come out in order idx 0,1,2…7, every other cycle; pending=0 after the 8th grant.
- Fairness: with ptr=5 after granting idx 4, assert req for bits 1 and 6 → next grant is idx 6, then idx 1 (wrap-around).
- Hold: offer idx 3 with ready=0 for 5 cycles → gnt and idx stay stable and valid stays high; the grant is accepted on the first cycle ready=1.
- Drop/collision:
  - bit 2 pending and not being accepted, req[2] pulses → drop_err=1 next cycle; it stays 1 until clr_err, then reads 0.
  - req[2] in the same cycle that grant 2 is accepted → pending[2] stays 1 and drop_err is not set.
- en=0 with req=8'hFF → pending is unchanged. rst asserted during OFFER → next cycle all outputs are at their reset values.
